gated_count_ctrl: RTL and testbench

Measurement sequencer for the event-counter datapath. On a start command it waits a programmable holdoff, then opens a counting gate for a programmable number of cycles. It then presents the captured count and an overflow flag on a valid/ready result port. It is the control layer that arms, gates, captures and hands off an N-bit event count, with a choice of wrap or saturate behaviour.

---
 rtl/gated_count_ctrl.sv | 136 +++++++++++++
 tb/tb_gated_count_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gated_count_ctrl.sv
// Measurement sequencer: start -> holdoff -> counting gate -> result held on a
// valid/ready port. Count either wraps (sticky overflow) or saturates at max.
module gated_count_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] holdoff_len,
  input  logic [LEN_WIDTH-1:0] gate_len,
  input  logic                 sat_mode,
  input  logic                 event_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLDOFF,
    S_GATE,
    S_REPORT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] timer_q, timer_d;
  logic [LEN_WIDTH-1:0] gate_len_q, gate_len_d;
  logic                 sat_q, sat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  // NOTE: every next-value is defaulted to its current value first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gate_len_d = gate_len_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          gate_len_d = gate_len;
          sat_d      = sat_mode;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          if (holdoff_len != '0) begin
            state_d = S_HOLDOFF;
            timer_d = holdoff_len;
          end else if (gate_len != '0) begin
            state_d = S_GATE;
            timer_d = gate_len;
          end else begin
            state_d = S_REPORT;
            timer_d = '0;
          end
        end
      end

      // timer holds the cycles remaining in the current phase, including this one
      S_HOLDOFF: begin
        timer_d = timer_q - 1'b1;
        if (timer_q == 1) begin
          if (gate_len_q != '0) begin
            state_d = S_GATE;
            timer_d = gate_len_q;
          end else begin
            state_d = S_REPORT;
          end
        end
      end

      S_GATE: begin
        timer_d = timer_q - 1'b1;
        if (event_in) begin
          if (cnt_q == CNT_MAX) begin
            if (!sat_q) cnt_d = '0;
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (sat_q && (cnt_q == CNT_MAX - 1'b1)) ovf_d = 1'b1;
          end
        end
        if (timer_q == 1) state_d = S_REPORT;
      end

      S_REPORT: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // abort outside IDLE discards the measurement, including a pending handshake
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      timer_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      gate_len_q <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gate_len_q <= gate_len_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_REPORT);
  assign cnt_out   = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_gated_count_ctrl.sv
// Directed + randomized bench for gated_count_ctrl; expected results come from
// an event-count model (popcount of gated events, then wrap or clamp).
module tb_gated_count_ctrl;

  localparam int CW   = 4;
  localparam int LW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [LW-1:0] holdoff_len;
  logic [LW-1:0] gate_len;
  logic          sat_mode;
  logic          event_in;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] cnt_out;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  gated_count_ctrl #(.CNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .holdoff_len(holdoff_len),
    .gate_len   (gate_len),
    .sat_mode   (sat_mode),
    .event_in   (event_in),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cnt_out    (cnt_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_cnt"},   cnt_out,   0);
    check({tag, "_ovf"},   overflow,  0);
  endtask

  // pat: 0 = events always high, 1 = alternating starting at 1, else random
  task automatic run_meas(input int h, input int g, input bit sat, input int pat,
                          input int wait_n, input bit do_hs);
    int ones;
    int exp_cnt;
    int exp_ovf;
    ones        = 0;
    holdoff_len = LW'(h);
    gate_len    = LW'(g);
    sat_mode    = sat;
    start       = 1'b1;
    step();
    start       = 1'b0;
    holdoff_len = LW'($urandom);
    gate_len    = LW'($urandom);
    sat_mode    = 1'($urandom);
    check("busy_rise", busy, 1);
    for (int i = 0; i < h; i++) begin
      event_in = (pat == 0) ? 1'b1 : 1'($urandom);
      check("valid_in_holdoff", out_valid, 0);
      step();
    end
    for (int i = 0; i < g; i++) begin
      case (pat)
        0:       event_in = 1'b1;
        1:       event_in = (i % 2 == 0);
        default: event_in = 1'($urandom);
      endcase
      ones += int'(event_in);
      check("valid_in_gate", out_valid, 0);
      step();
    end
    event_in = 1'b0;
    if (sat) begin
      exp_cnt = (ones > MAXV) ? MAXV : ones;
      exp_ovf = (ones >= MAXV) ? 1 : 0;
    end else begin
      exp_cnt = ones % (MAXV + 1);
      exp_ovf = (ones > MAXV) ? 1 : 0;
    end
    check("valid_first", out_valid, 1);
    check("cnt_first", cnt_out, exp_cnt);
    check("ovf_first", overflow, exp_ovf);
    for (int i = 0; i < wait_n; i++) begin
      out_ready = 1'b0;
      event_in  = 1'($urandom);
      start     = 1'($urandom);
      step();
      check("valid_held", out_valid, 1);
      check("cnt_held", cnt_out, exp_cnt);
      check("ovf_held", overflow, exp_ovf);
    end
    start    = 1'b0;
    event_in = 1'b0;
    if (do_hs) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("valid_after_hs", out_valid, 0);
      check("busy_after_hs", busy, 0);
      check("cnt_retained", cnt_out, exp_cnt);
      check("ovf_retained", overflow, exp_ovf);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    holdoff_len = '0;
    gate_len    = '0;
    sat_mode    = 1'b0;
    event_in    = 1'b0;
    out_ready   = 1'b0;
    step();
    step();
    check_idle_zero("reset");
    reset = 1'b0;
    step();
    check_idle_zero("post_reset");

    // basic gated count, out_ready high throughout
    out_ready = 1'b1;
    run_meas(3, 10, 1'b0, 0, 0, 1'b1);

    // zero lengths and alternating events
    run_meas(0, 0, 1'b0, 0, 0, 1'b1);
    run_meas(0, 5, 1'b0, 1, 0, 1'b1);

    // wrap versus saturate at the counter limit
    run_meas(2, 20, 1'b0, 0, 0, 1'b1);
    run_meas(2, 20, 1'b1, 0, 0, 1'b1);
    run_meas(1, 15, 1'b0, 0, 0, 1'b1);
    run_meas(1, 15, 1'b1, 0, 0, 1'b1);
    run_meas(0, 14, 1'b1, 0, 0, 1'b1);

    // backpressure with start/event toggling during the wait
    run_meas(2, 9, 1'b0, 2, 7, 1'b1);

    // abort+start together in IDLE: stays idle, previous result retained
    run_meas(1, 6, 1'b0, 0, 0, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    gate_len = 8'd4;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_valid", out_valid, 0);
    check("idle_abort_cnt", cnt_out, 6);
    step();
    check("idle_abort_busy2", busy, 0);

    // abort in gate cycle 4 of 10
    holdoff_len = 8'd2;
    gate_len    = 8'd10;
    sat_mode    = 1'b0;
    start       = 1'b1;
    step();
    start    = 1'b0;
    event_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort    = 1'b0;
    event_in = 1'b0;
    check_idle_zero("abort_gate");
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_no_valid", out_valid, 0);
    end

    // abort while a result waits in REPORT
    run_meas(1, 7, 1'b0, 0, 2, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle_zero("abort_report");

    // reset mid-HOLDOFF
    holdoff_len = 8'd5;
    gate_len    = 8'd3;
    start       = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_zero("rst_holdoff");

    // reset mid-REPORT, then a clean measurement
    run_meas(0, 9, 1'b1, 0, 1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_zero("rst_report");
    run_meas(2, 12, 1'b0, 2, 1, 1'b1);

    // randomized measurements
    for (int k = 0; k < 12; k++) begin
      run_meas(int'($urandom_range(0, 6)), int'($urandom_range(0, 40)),
               1'($urandom), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
